shot_display: RTL

Downstream consumer of the shot-clock counter. Takes its count[3:0], shoot and buzz outputs and produces:
- two registered 7-segment digit drives;
- a stretched buzzer drive with display blink on expiry;
- saturating tallies of shots and shot-clock violations for the scoreboard.
All inputs come from logic on the same clock.

---
 rtl/shot_display.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/shot_display.sv
// Display, buzzer-stretch and scoreboard tally stage fed by the shot-clock counter.
// Every output is a register; inputs are resampled and edge-detected locally.
module shot_display #(
    parameter int BUZZ_CYCLES    = 8,
    parameter int BLINK_HALF     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] count,
    input  logic       shoot,
    input  logic       buzz,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       buzzer,
    output logic [7:0] shot_tally,
    output logic [3:0] viol_count
);

    typedef enum logic [1:0] {RUN, ALARM, HOLD} state_t;

    localparam int TW = (BUZZ_CYCLES > 2) ? $clog2(BUZZ_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BUZZ_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);
    localparam logic [6:0]    SEG_BLANK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'h3F;
            4'd1:    segs = 7'h06;
            4'd2:    segs = 7'h5B;
            4'd3:    segs = 7'h4F;
            4'd4:    segs = 7'h66;
            4'd5:    segs = 7'h6D;
            4'd6:    segs = 7'h7D;
            4'd7:    segs = 7'h07;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h6F;
            default: segs = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~segs : segs;
    endfunction

    state_t           r_state;
    logic [3:0]       r_countQ;
    logic             r_shootQ;
    logic             r_shootQQ;
    logic             r_buzzQ;
    logic             r_buzzQQ;
    logic [TW-1:0]    r_timer;
    logic [BW-1:0]    r_blinkCnt;
    logic             r_blinkOn;
    logic [6:0]       r_segTens;
    logic [6:0]       r_segOnes;
    logic             r_buzzer;
    logic [7:0]       r_shotTally;
    logic [3:0]       r_violCount;

    logic             w_riseShoot;
    logic             w_riseBuzz;
    logic             w_acceptViol;
    logic [3:0]       w_onesVal;
    logic [6:0]       w_tensSeg;
    logic [6:0]       w_onesSeg;

    assign w_riseShoot  = r_shootQ & ~r_shootQQ;
    assign w_riseBuzz   = r_buzzQ & ~r_buzzQQ;
    assign w_acceptViol = w_riseBuzz && (r_state != ALARM);

    // Count never exceeds 15, so the tens digit is either blank or "1".
    assign w_onesVal = (r_countQ >= 4'd10) ? (r_countQ - 4'd10) : r_countQ;
    assign w_tensSeg = (r_countQ >= 4'd10) ? decode(4'd1) : SEG_BLANK;
    assign w_onesSeg = decode(w_onesVal);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_countQ  <= '0;
            r_shootQ  <= 1'b0;
            r_shootQQ <= 1'b0;
            r_buzzQ   <= 1'b0;
            r_buzzQQ  <= 1'b0;
        end else begin
            r_countQ  <= count;
            r_shootQ  <= shoot;
            r_shootQQ <= r_shootQ;
            r_buzzQ   <= buzz;
            r_buzzQQ  <= r_buzzQ;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_shotTally <= '0;
            r_violCount <= '0;
        end else begin
            if (w_riseShoot && (r_shotTally != 8'hFF))
                r_shotTally <= r_shotTally + 8'd1;
            if (w_acceptViol && (r_violCount != 4'hF))
                r_violCount <= r_violCount + 4'd1;
        end
    end

    // Segment and buzzer registers are loaded from the state held before each edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= RUN;
            r_timer    <= '0;
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b0;
            r_segTens  <= SEG_BLANK;
            r_segOnes  <= SEG_BLANK;
            r_buzzer   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_segTens <= w_tensSeg;
                    r_segOnes <= w_onesSeg;
                    r_buzzer  <= 1'b0;
                    if (w_riseBuzz) begin
                        r_state    <= ALARM;
                        r_buzzer   <= 1'b1;
                        r_timer    <= TIMER_LOAD;
                        r_blinkCnt <= BLINK_LOAD;
                        r_blinkOn  <= 1'b1;
                    end
                end
                ALARM: begin
                    if (r_timer == '0) begin
                        r_state   <= HOLD;
                        r_buzzer  <= 1'b0;
                        r_segTens <= w_tensSeg;
                        r_segOnes <= w_onesSeg;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                        if (r_blinkCnt == '0) begin
                            r_blinkCnt <= BLINK_LOAD;
                            r_blinkOn  <= ~r_blinkOn;
                            r_segTens  <= r_blinkOn ? SEG_BLANK : w_tensSeg;
                            r_segOnes  <= r_blinkOn ? SEG_BLANK : w_onesSeg;
                        end else begin
                            r_blinkCnt <= r_blinkCnt - BW'(1);
                            r_segTens  <= r_blinkOn ? w_tensSeg : SEG_BLANK;
                            r_segOnes  <= r_blinkOn ? w_onesSeg : SEG_BLANK;
                        end
                    end
                end
                HOLD: begin
                    r_segTens <= SEG_BLANK;
                    r_segOnes <= w_onesSeg;
                    r_buzzer  <= 1'b0;
                    if (w_riseBuzz) begin
                        r_state    <= ALARM;
                        r_buzzer   <= 1'b1;
                        r_timer    <= TIMER_LOAD;
                        r_blinkCnt <= BLINK_LOAD;
                        r_blinkOn  <= 1'b1;
                    end else if (r_countQ != 4'd0) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_buzzer <= 1'b0;
                end
            endcase
        end
    end

    assign seg_tens   = r_segTens;
    assign seg_ones   = r_segOnes;
    assign buzzer     = r_buzzer;
    assign shot_tally = r_shotTally;
    assign viol_count = r_violCount;

endmodule
